sm4_round_engine: RTL and testbench



---
 rtl/sm4_pkg.sv | 45 ++++
 rtl/sm4_round_f.sv | 27 ++
 rtl/sm4_round_engine.sv | 150 +++++++++++++++
 tb/tb_sm4_round_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// SM4 shared definitions: FSM state encoding, round count, S-box lookup and
// 32-bit rotate. Imported by sm4_round_f and sm4_round_engine.
package sm4_pkg;

  // Standard SM4 round count; also the number of 32-bit keys carried on RK_i.
  localparam int unsigned SM4_ROUNDS = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sm4_state_e;

  // S-box flattened MSB-first: entry 0 sits in bits [2047:2040].
  localparam logic [2047:0] SBOX_TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sm4_sbox(input logic [7:0] a);
    logic [10:0] lsb;
    // Entry a starts at bit 8*(255-a) = {~a, 3'b000}.
    lsb = {~a, 3'b000};
    return SBOX_TABLE[lsb +: 8];
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sm4_round_f.sv
// SM4 round function (combinational).
//   x0_i..x3_i : current state words X0..X3
//   rk_i       : round key for this round
//   x_new_o    : X0 ^ L(tau(X1 ^ X2 ^ X3 ^ rk))
module sm4_round_f
  import sm4_pkg::*;
(
  input  logic [31:0] x0_i,
  input  logic [31:0] x1_i,
  input  logic [31:0] x2_i,
  input  logic [31:0] x3_i,
  input  logic [31:0] rk_i,
  output logic [31:0] x_new_o
);

  logic [31:0] mix;
  logic [31:0] sub;

  always_comb begin
    mix = x1_i ^ x2_i ^ x3_i ^ rk_i;
    sub = {sm4_sbox(mix[31:24]), sm4_sbox(mix[23:16]),
           sm4_sbox(mix[15:8]),  sm4_sbox(mix[7:0])};
    x_new_o = x0_i ^ sub ^ rotl32(sub, 2) ^ rotl32(sub, 10) ^ rotl32(sub, 18) ^
              rotl32(sub, 24);
  end

endmodule

// File: rtl/sm4_round_engine.sv
// Iterative SM4 block engine: one round per clock, valid/ready in and out.
//   CLK_i, RST_N_i            : clock, asynchronous active-low reset
//   RK_i, RK_READY_i          : 32 expanded round keys (rk[0] in [1023:992]) and their valid
//   DIN_i, DIN_VALID_i/READY_o: input block (X0 in [127:96]) and handshake
//   DEC_i                     : 1 = decrypt, sampled on acceptance
//   DOUT_o, DOUT_VALID_o/READY_i: result block and handshake
//   BUSY_o                    : high while a block is in flight (RUN or DONE)
// Build option: define SM4_DECRYPT_EN to honour DEC_i (reverse key order);
// otherwise the engine is encrypt-only and DEC_i is ignored.
module sm4_round_engine
  import sm4_pkg::*;
#(
  parameter int unsigned ROUNDS = SM4_ROUNDS,
  parameter int unsigned CNT_W  = 5
) (
  input  logic          CLK_i,
  input  logic          RST_N_i,
  input  logic [1023:0] RK_i,
  input  logic          RK_READY_i,
  input  logic [127:0]  DIN_i,
  input  logic          DIN_VALID_i,
  output logic          DIN_READY_o,
  input  logic          DEC_i,
  output logic [127:0]  DOUT_o,
  output logic          DOUT_VALID_o,
  input  logic          DOUT_READY_i,
  output logic          BUSY_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ROUNDS - 1);

  sm4_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      x0_q, x1_q, x2_q, x3_q;
  logic [127:0]     dout_q;
  logic             dout_valid_q;
  logic             busy_q;
  // Set in IDLE once out of reset; keeps DIN_READY_o low while reset is held.
  logic             idle_q;

`ifdef SM4_DECRYPT_EN
  logic             mode_q;
`else
  logic             unused_dec;
  assign unused_dec = DEC_i;
`endif

  // Unpack the key bus so rk_w[i] is rk[i].
  logic [31:0] rk_w [SM4_ROUNDS];
  for (genvar gi = 0; gi < SM4_ROUNDS; gi++) begin : g_rk
    assign rk_w[gi] = RK_i[32*(SM4_ROUNDS-gi)-1 -: 32];
  end

  logic [4:0]  rk_idx;
  logic [31:0] rk_sel;
  logic [31:0] x_new;

  always_comb begin
`ifdef SM4_DECRYPT_EN
    rk_idx = mode_q ? 5'(LastCnt - cnt_q) : 5'(cnt_q);
`else
    rk_idx = 5'(cnt_q);
`endif
    rk_sel = rk_w[rk_idx];
  end

  sm4_round_f u_round_f (
    .x0_i    (x0_q),
    .x1_i    (x1_q),
    .x2_i    (x2_q),
    .x3_i    (x3_q),
    .rk_i    (rk_sel),
    .x_new_o (x_new)
  );

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      idle_q       <= 1'b0;
`ifdef SM4_DECRYPT_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          idle_q <= 1'b1;
          if (idle_q && RK_READY_i && DIN_VALID_i) begin
            x0_q    <= DIN_i[127:96];
            x1_q    <= DIN_i[95:64];
            x2_q    <= DIN_i[63:32];
            x3_q    <= DIN_i[31:0];
            cnt_q   <= '0;
`ifdef SM4_DECRYPT_EN
            mode_q  <= DEC_i;
`endif
            state_q <= StRun;
            busy_q  <= 1'b1;
            idle_q  <= 1'b0;
          end
        end
        StRun: begin
          if (!RK_READY_i) begin
            // Keys withdrawn: drop the block, keep X as-is.
            state_q <= StIdle;
            busy_q  <= 1'b0;
            idle_q  <= 1'b1;
          end else begin
            x0_q <= x1_q;
            x1_q <= x2_q;
            x2_q <= x3_q;
            x3_q <= x_new;
            if (cnt_q == LastCnt) begin
              // Reverse transform R applied on the post-shift words.
              dout_q       <= {x_new, x3_q, x2_q, x1_q};
              dout_valid_q <= 1'b1;
              state_q      <= StDone;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          if (DOUT_READY_i) begin
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            idle_q       <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign DIN_READY_o  = idle_q & RK_READY_i;
  assign DOUT_o       = dout_q;
  assign DOUT_VALID_o = dout_valid_q;
  assign BUSY_o       = busy_q;

endmodule

// File: tb/tb_sm4_round_engine.sv
// Directed bench for sm4_round_engine with an independent SM4 reference model
// (own S-box, key expansion and cipher) feeding an expected-result queue.
module tb_sm4_round_engine;

  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] FK  = 128'ha3b1bac656aa3350677d9197b27022dc;

  localparam logic [2047:0] TB_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic          CLK_i = 1'b0;
  logic          RST_N_i;
  logic [1023:0] RK_i;
  logic          RK_READY_i;
  logic [127:0]  DIN_i;
  logic          DIN_VALID_i;
  logic          DIN_READY_o;
  logic          DEC_i;
  logic [127:0]  DOUT_o;
  logic          DOUT_VALID_o;
  logic          DOUT_READY_i;
  logic          BUSY_o;

  sm4_round_engine dut (
    .CLK_i        (CLK_i),
    .RST_N_i      (RST_N_i),
    .RK_i         (RK_i),
    .RK_READY_i   (RK_READY_i),
    .DIN_i        (DIN_i),
    .DIN_VALID_i  (DIN_VALID_i),
    .DIN_READY_o  (DIN_READY_o),
    .DEC_i        (DEC_i),
    .DOUT_o       (DOUT_o),
    .DOUT_VALID_o (DOUT_VALID_o),
    .DOUT_READY_i (DOUT_READY_i),
    .BUSY_o       (BUSY_o)
  );

  always #5 CLK_i = ~CLK_i;

  int            n_chk = 0;
  int            n_fail = 0;
  int            n_out = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            acc_hist[$];
  logic [127:0]  exp_q[$];
  logic [31:0]   tb_rk [32];
  logic          vld_prev = 1'b0;

  always @(posedge CLK_i) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [10:0] lsb;
    lsb = {~a, 3'b000};
    return TB_SBOX[lsb +: 8];
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] t_fn(input logic [31:0] x, input bit key);
    logic [31:0] b;
    b = {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    if (key) return b ^ rl(b, 13) ^ rl(b, 23);
    return b ^ rl(b, 2) ^ rl(b, 10) ^ rl(b, 18) ^ rl(b, 24);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] blk, input logic dec);
    logic [31:0] x[4];
    logic [31:0] xn;
    logic        d;
`ifdef SM4_DECRYPT_EN
    d = dec;
`else
    d = 1'b0;
    if (dec) d = 1'b0;
`endif
    for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      xn = x[0] ^ t_fn(x[1] ^ x[2] ^ x[3] ^ (d ? tb_rk[31-i] : tb_rk[i]), 1'b0);
      x[0] = x[1]; x[1] = x[2]; x[2] = x[3]; x[3] = xn;
    end
    return {x[3], x[2], x[1], x[0]};
  endfunction

  task automatic expand_key();
    logic [31:0] k[4];
    logic [31:0] ck;
    logic [31:0] nk;
    for (int i = 0; i < 4; i++) k[i] = KEY[127-32*i -: 32] ^ FK[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
      nk = k[0] ^ t_fn(k[1] ^ k[2] ^ k[3] ^ ck, 1'b1);
      tb_rk[i] = nk;
      k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = nk;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge CLK_i) begin
    if (RST_N_i === 1'b1) begin
      if (DIN_VALID_i && DIN_READY_o) begin
        exp_q.push_back(model(DIN_i, DEC_i));
        acc_cyc = cyc + 1;
        acc_hist.push_back(acc_cyc);
      end
      if (DOUT_VALID_o && !vld_prev) chk("latency", 256'(cyc - acc_cyc), 256'(32));
      if (DOUT_VALID_o && DOUT_READY_i) begin
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_output", DOUT_o, 256'(0));
        else chk("dout_model", DOUT_o, exp_q.pop_front());
      end
      vld_prev = DOUT_VALID_o;
    end else begin
      vld_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK_i);
    #1;
  endtask

  task automatic send(input logic [127:0] blk, input logic dec);
    logic hs;
    logic ok;
    DIN_i = blk;
    DEC_i = dec;
    DIN_VALID_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_i);
      hs = DIN_VALID_i && DIN_READY_o;
      @(posedge CLK_i);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 256'(ok), 256'(1));
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (DOUT_VALID_o) break;
      tick();
    end
    chk(tag, 256'(DOUT_VALID_o), 256'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain", 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] hold_val;
    logic [127:0] exp2;
    logic [127:0] blk[3];
    int           outs_before;
    int           n;

    RST_N_i = 1'b0;
    RK_READY_i = 1'b1;
    DIN_i = PT;
    DIN_VALID_i = 1'b1;
    DEC_i = 1'b0;
    DOUT_READY_i = 1'b0;
    expand_key();
    for (int i = 0; i < 32; i++) RK_i[1023-32*i -: 32] = tb_rk[i];
    chk("model_vector", model(PT, 1'b0), CT);

    // Reset state, with keys ready and a block offered.
    repeat (3) tick();
    chk("reset_outputs", {DOUT_o, DOUT_VALID_o, DIN_READY_o, BUSY_o}, 256'(0));
    RST_N_i = 1'b1;
    DIN_VALID_i = 1'b0;
    tick();

    // 1: known-answer encryption, ready held high from the start.
    DOUT_READY_i = 1'b1;
    send(PT, 1'b0);
    DIN_VALID_i = 1'b0;
    chk("t1_busy", {BUSY_o, DIN_READY_o}, 256'(2'b10));
    wait_valid("t1_valid");
    chk("t1_ct", DOUT_o, CT);
    tick();
    chk("t1_idle", {DOUT_VALID_o, BUSY_o}, 256'(0));

    // 2+3: decrypt request (DEC_i toggled mid-run), output backpressure.
    DOUT_READY_i = 1'b0;
    send(CT, 1'b1);
    DIN_VALID_i = 1'b0;
    DEC_i = 1'b0;
`ifdef SM4_DECRYPT_EN
    exp2 = PT;
`else
    exp2 = model(CT, 1'b0);
`endif
    wait_valid("t2_valid");
    chk("t2_out", DOUT_o, exp2);
    hold_val = DOUT_o;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold", {DOUT_VALID_o, DIN_READY_o, BUSY_o, DOUT_o},
          {1'b1, 1'b0, 1'b1, hold_val});
    end
    DOUT_READY_i = 1'b1;
    tick();
    chk("t3_release", {DOUT_VALID_o, BUSY_o, DIN_READY_o}, 256'(3'b001));

    // 4: back-to-back with valid and ready held high.
    blk[0] = 128'h00112233445566778899aabbccddeeff;
    blk[1] = 128'hdeadbeefcafef00d0123456789abcdef;
    blk[2] = 128'hffffffff00000000a5a5a5a55a5a5a5a;
    for (int k = 0; k < 3; k++) send(blk[k], k == 1);
    DIN_VALID_i = 1'b0;
    n = acc_hist.size();
    chk("t4_space_a", 256'(acc_hist[n-2] - acc_hist[n-3]), 256'(34));
    chk("t4_space_b", 256'(acc_hist[n-1] - acc_hist[n-2]), 256'(34));
    drain();

    // 5: key withdrawal at round 10 aborts the block.
    send(128'h13579bdf2468ace0fedcba9876543210, 1'b0);
    DIN_VALID_i = 1'b0;
    outs_before = n_out;
    repeat (10) tick();
    RK_READY_i = 1'b0;
    tick();
    chk("t5_abort", {BUSY_o, DOUT_VALID_o, DIN_READY_o}, 256'(0));
    exp_q.delete();
    DIN_VALID_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_blocked", {DIN_READY_o, BUSY_o, DOUT_VALID_o}, 256'(0));
    end
    chk("t5_no_output", 256'(n_out), 256'(outs_before));
    DIN_VALID_i = 1'b0;
    RK_READY_i = 1'b1;
    #1;
    chk("t5_ready_back", 256'(DIN_READY_o), 256'(1));
    send(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0);
    DIN_VALID_i = 1'b0;
    drain();

    // 6: asynchronous reset at round 20, then known answer again.
    send(PT, 1'b0);
    DIN_VALID_i = 1'b0;
    repeat (20) tick();
    #2;
    RST_N_i = 1'b0;
    #1;
    chk("t6_reset", {DOUT_o, DOUT_VALID_o, DIN_READY_o, BUSY_o}, 256'(0));
    exp_q.delete();
    tick();
    tick();
    RST_N_i = 1'b1;
    send(PT, 1'b0);
    DIN_VALID_i = 1'b0;
    wait_valid("t6_valid");
    chk("t6_ct", DOUT_o, CT);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
